character_registers: RTL and testbench

Position/direction store for the five on-screen characters (0 = Pacman, 1–4 = ghosts).
- Sits directly upstream of the character display controller: it returns `char_x`/`char_y` for the `charType` index that controller presents, plus Pacman's facing.
- Once per game tick, a small FSM advances every character one pixel in its commanded direction.
- With collision detection compiled in, it then checks Pacman against each ghost.
- Directions arrive over a valid/ready handshake from the input/ghost-AI logic.

---
 rtl/pacman_pkg.sv | 68 ++++++
 rtl/char_step.sv | 29 ++
 rtl/character_registers.sv | 173 +++++++++++++++++
 tb/tb_character_registers.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared Pacman definitions: direction codes, character indices, start positions,
// sprite size and the character-register FSM states.
package pacman_pkg;

  localparam logic [2:0] DIR_STOP  = 3'd0;
  localparam logic [2:0] DIR_LEFT  = 3'd1;
  localparam logic [2:0] DIR_RIGHT = 3'd2;
  localparam logic [2:0] DIR_UP    = 3'd3;
  localparam logic [2:0] DIR_DOWN  = 3'd4;

  localparam logic [2:0] CHAR_PAC  = 3'd0;

  localparam logic [7:0] PAC_START_X = 8'd50;
  localparam logic [7:0] PAC_START_Y = 8'd80;

  localparam logic [7:0] SPRITE_SIZE = 8'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic logic [7:0] start_x(input logic [2:0] idx);
    case (idx)
      3'd0:    return PAC_START_X;
      3'd1:    return 8'd45;
      3'd2:    return 8'd50;
      3'd3:    return 8'd55;
      3'd4:    return 8'd50;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] start_y(input logic [2:0] idx);
    case (idx)
      3'd0:    return PAC_START_Y;
      3'd1:    return 8'd50;
      3'd2:    return 8'd50;
      3'd3:    return 8'd50;
      3'd4:    return 8'd40;
      default: return 8'd0;
    endcase
  endfunction

  // Codes 5-7 are reserved and behave as STOP.
  function automatic logic [2:0] dir_decode(input logic [2:0] code);
    if (code > DIR_DOWN) begin
      return DIR_STOP;
    end else begin
      return code;
    end
  endfunction

  // 9-bit difference so that e.g. 2 - 250 cannot wrap into a small value.
  function automatic logic within_sprite(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[8]) begin
      d = 9'd0 - d;
    end else begin
      d = d;
    end
    return (d < {1'b0, SPRITE_SIZE});
  endfunction

endpackage

// File: rtl/char_step.sv
// Combinational next position for one character: horizontal tunnel wrap, vertical clamp.
module char_step
  import pacman_pkg::*;
(
  input  logic [7:0] i_x,
  input  logic [7:0] i_y,
  input  logic [2:0] i_dir,
  input  logic [7:0] i_x_max,
  input  logic [7:0] i_y_max,
  output logic [7:0] o_x,
  output logic [7:0] o_y
);

  always_comb begin
    o_x = i_x;
    o_y = i_y;
    case (i_dir)
      DIR_LEFT:  o_x = (i_x == 8'd0)     ? i_x_max : i_x - 8'd1;
      DIR_RIGHT: o_x = (i_x >= i_x_max)  ? 8'd0    : i_x + 8'd1;
      DIR_UP:    o_y = (i_y == 8'd0)     ? 8'd0    : i_y - 8'd1;
      DIR_DOWN:  o_y = (i_y >= i_y_max)  ? i_y_max : i_y + 8'd1;
      default: begin
        o_x = i_x;
        o_y = i_y;
      end
    endcase
  end

endmodule

// File: rtl/character_registers.sv
// Position/direction store for Pacman and the ghosts, stepped once per game tick.
// Optional Pacman/ghost collision check is enabled by defining CHARREG_COLLISION_EN.
module character_registers
  import pacman_pkg::*;
#(
  parameter int         NUM_CHARS = 5,
  parameter logic [7:0] X_MAX     = 8'd103,
  parameter logic [7:0] Y_MAX     = 8'd113
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] char_sel,
  output logic [7:0] char_x,
  output logic [7:0] char_y,
  output logic       pac_orient,
  input  logic       tick,
  input  logic       dir_valid,
  output logic       dir_ready,
  input  logic [2:0] dir_char,
  input  logic [2:0] dir_code,
  output logic       busy,
  output logic       collision,
  output logic       tick_overrun
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_CHARS - 1);

  state_t     r_state, w_state_nxt;
  logic [2:0] r_idx, w_idx_nxt;
  logic [7:0] r_x   [NUM_CHARS];
  logic [7:0] r_y   [NUM_CHARS];
  logic [2:0] r_dir [NUM_CHARS];
  logic       r_pac_orient;
  logic       r_tick_overrun;
  logic [7:0] w_cur_x, w_cur_y, w_step_x, w_step_y;
  logic [2:0] w_cur_dir;
  logic       w_dir_accept;

  assign w_dir_accept = dir_valid && (r_state == ST_IDLE);
  assign dir_ready    = (r_state == ST_IDLE);
  assign busy         = (r_state != ST_IDLE);
  assign pac_orient   = r_pac_orient;
  assign tick_overrun = r_tick_overrun;

  // Display read port and the character currently addressed by the FSM
  always_comb begin
    char_x    = 8'd0;
    char_y    = 8'd0;
    w_cur_x   = 8'd0;
    w_cur_y   = 8'd0;
    w_cur_dir = DIR_STOP;
    for (int i = 0; i < NUM_CHARS; i++) begin
      char_x    = (char_sel == 3'(i)) ? r_x[i]   : char_x;
      char_y    = (char_sel == 3'(i)) ? r_y[i]   : char_y;
      w_cur_x   = (r_idx == 3'(i))    ? r_x[i]   : w_cur_x;
      w_cur_y   = (r_idx == 3'(i))    ? r_y[i]   : w_cur_y;
      w_cur_dir = (r_idx == 3'(i))    ? r_dir[i] : w_cur_dir;
    end
  end

  char_step u_step (
    .i_x     (w_cur_x),
    .i_y     (w_cur_y),
    .i_dir   (w_cur_dir),
    .i_x_max (X_MAX),
    .i_y_max (Y_MAX),
    .o_x     (w_step_x),
    .o_y     (w_step_y)
  );

  // Frame sequencer next-state
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (tick) begin
          w_state_nxt = ST_UPDATE;
          w_idx_nxt   = 3'd0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_UPDATE: begin
        if (r_idx == LAST_IDX) begin
`ifdef CHARREG_COLLISION_EN
          w_state_nxt = ST_CHECK;
          w_idx_nxt   = 3'd1;
`else
          w_state_nxt = ST_DONE;
`endif
        end else begin
          w_idx_nxt = r_idx + 3'd1;
        end
      end
      ST_CHECK: begin
        if (r_idx == LAST_IDX) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_idx_nxt = r_idx + 3'd1;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Frame sequencer state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_idx   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Position/direction register file, Pacman facing and overrun flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        r_x[i]   <= start_x(3'(i));
        r_y[i]   <= start_y(3'(i));
        r_dir[i] <= DIR_STOP;
      end
      r_pac_orient   <= 1'b0;
      r_tick_overrun <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        if ((r_state == ST_UPDATE) && (r_idx == 3'(i))) begin
          r_x[i] <= w_step_x;
          r_y[i] <= w_step_y;
        end
        if (w_dir_accept && (dir_char == 3'(i))) begin
          r_dir[i] <= dir_decode(dir_code);
        end
      end
      if (w_dir_accept && (dir_char == CHAR_PAC) && (dir_code == DIR_LEFT)) begin
        r_pac_orient <= 1'b0;
      end else if (w_dir_accept && (dir_char == CHAR_PAC) && (dir_code == DIR_RIGHT)) begin
        r_pac_orient <= 1'b1;
      end
      if (tick && (r_state != ST_IDLE)) begin
        r_tick_overrun <= 1'b1;
      end
    end
  end

`ifdef CHARREG_COLLISION_EN
  logic r_hit, r_collision;

  // Frame-local hit flag, published to collision once every ghost has been checked
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hit       <= 1'b0;
      r_collision <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE:  r_hit <= tick ? 1'b0 : r_hit;
        ST_CHECK: r_hit <= r_hit | (within_sprite(r_x[0], w_cur_x) & within_sprite(r_y[0], w_cur_y));
        ST_DONE:  r_collision <= r_hit;
        default:  r_hit <= r_hit;
      endcase
    end
  end

  assign collision = r_collision;
`else
  assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_character_registers.sv
// Self-checking bench for character_registers: reset table, directed corner sequences,
// and randomized frames checked against a position/direction model.
module tb_character_registers;

  localparam int N  = 5;
  localparam int XM = 103;
  localparam int YM = 113;
`ifdef CHARREG_COLLISION_EN
  localparam int EXP_BUSY = 2 * N;
  localparam int COLL_EN  = 1;
`else
  localparam int EXP_BUSY = N + 1;
  localparam int COLL_EN  = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] char_sel;
  logic [7:0] char_x, char_y;
  logic       pac_orient;
  logic       tick;
  logic       dir_valid;
  logic       dir_ready;
  logic [2:0] dir_char;
  logic [2:0] dir_code;
  logic       busy;
  logic       collision;
  logic       tick_overrun;

  int n_vec = 0;
  int n_err = 0;

  int mx [N];
  int my [N];
  int mdir [N];
  int morient, mcoll, movr;

  typedef struct {
    logic [2:0] sel;
    int         x;
    int         y;
  } rd_vec_t;
  rd_vec_t rst_tab [7];

  always #5 clk = ~clk;

  character_registers dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .char_sel     (char_sel),
    .char_x       (char_x),
    .char_y       (char_y),
    .pac_orient   (pac_orient),
    .tick         (tick),
    .dir_valid    (dir_valid),
    .dir_ready    (dir_ready),
    .dir_char     (dir_char),
    .dir_code     (dir_code),
    .busy         (busy),
    .collision    (collision),
    .tick_overrun (tick_overrun)
  );

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mx = '{50, 45, 50, 55, 50};
    my = '{80, 50, 50, 50, 40};
    for (int i = 0; i < N; i++) mdir[i] = 0;
    morient = 0;
    mcoll   = 0;
    movr    = 0;
  endtask

  task automatic model_dir(input int ch, input int code);
    if (ch < N) mdir[ch] = (code <= 4) ? code : 0;
    if (ch == 0 && code == 1) morient = 0;
    if (ch == 0 && code == 2) morient = 1;
  endtask

  task automatic model_frame();
    int dx, dy, hit;
    for (int i = 0; i < N; i++) begin
      case (mdir[i])
        1: mx[i] = (mx[i] == 0)  ? XM : mx[i] - 1;
        2: mx[i] = (mx[i] == XM) ? 0  : mx[i] + 1;
        3: my[i] = (my[i] == 0)  ? 0  : my[i] - 1;
        4: my[i] = (my[i] == YM) ? YM : my[i] + 1;
        default: ;
      endcase
    end
    hit = 0;
    for (int g = 1; g < N; g++) begin
      dx = mx[0] - mx[g];
      dy = my[0] - my[g];
      if (dx < 0) dx = -dx;
      if (dy < 0) dy = -dy;
      if (dx < 5 && dy < 5) hit = 1;
    end
    mcoll = (COLL_EN != 0) ? hit : 0;
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < N; i++) begin
      char_sel = 3'(i);
      #1;
      check($sformatf("%s x[%0d]", tag, i), int'(char_x), mx[i]);
      check($sformatf("%s y[%0d]", tag, i), int'(char_y), my[i]);
    end
    check({tag, " pac_orient"}, int'(pac_orient), morient);
    check({tag, " collision"}, int'(collision), mcoll);
    check({tag, " tick_overrun"}, int'(tick_overrun), movr);
    check({tag, " busy idle"}, int'(busy), 0);
  endtask

  task automatic wait_ready();
    int cnt;
    cnt = 0;
    while (!dir_ready && cnt < 100) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    check("dir_ready wait", int'(dir_ready), 1);
  endtask

  task automatic send_dir(input int ch, input int code);
    wait_ready();
    dir_valid = 1'b1;
    dir_char  = 3'(ch);
    dir_code  = 3'(code);
    @(posedge clk);
    #1;
    dir_valid = 1'b0;
    model_dir(ch, code);
  endtask

  task automatic run_tick(input int with_dir, input int ch, input int code);
    int cnt;
    wait_ready();
    tick = 1'b1;
    if (with_dir != 0) begin
      dir_valid = 1'b1;
      dir_char  = 3'(ch);
      dir_code  = 3'(code);
    end
    @(posedge clk);
    #1;
    tick      = 1'b0;
    dir_valid = 1'b0;
    if (with_dir != 0) model_dir(ch, code);
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    check("busy length", cnt, EXP_BUSY);
    model_frame();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, bad_ready;

    rst_tab[0] = '{3'd0, 50, 80};
    rst_tab[1] = '{3'd1, 45, 50};
    rst_tab[2] = '{3'd2, 50, 50};
    rst_tab[3] = '{3'd3, 55, 50};
    rst_tab[4] = '{3'd4, 50, 40};
    rst_tab[5] = '{3'd5, 0, 0};
    rst_tab[6] = '{3'd7, 0, 0};

    reset_n   = 1'b0;
    char_sel  = 3'd0;
    tick      = 1'b0;
    dir_valid = 1'b0;
    dir_char  = 3'd0;
    dir_code  = 3'd0;
    #12;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // reset values and read port, including out-of-range selects
    for (int i = 0; i < 7; i++) begin
      char_sel = rst_tab[i].sel;
      #1;
      check($sformatf("reset x sel%0d", rst_tab[i].sel), int'(char_x), rst_tab[i].x);
      check($sformatf("reset y sel%0d", rst_tab[i].sel), int'(char_y), rst_tab[i].y);
    end
    check("reset pac_orient", int'(pac_orient), 0);
    check("reset dir_ready", int'(dir_ready), 1);
    check("reset busy", int'(busy), 0);
    check("reset collision", int'(collision), 0);
    check("reset tick_overrun", int'(tick_overrun), 0);
    model_reset();

    // Pacman RIGHT then three frames
    send_dir(0, 2);
    for (int t = 0; t < 3; t++) run_tick(0, 0, 0);
    char_sel = 3'd0;
    #1;
    check("pac x after 3 right", int'(char_x), 53);
    check("pac orient right", int'(pac_orient), 1);
    compare_all("right3");

    // ghost 1 tunnel wrap at x=0, Pacman clamp at y=0
    send_dir(1, 1);
    send_dir(0, 3);
    for (int t = 1; t <= 81; t++) begin
      run_tick(0, 0, 0);
      char_sel = 3'd1;
      #1;
      if (t == 45) check("ghost1 reaches x0", int'(char_x), 0);
      if (t == 46) check("ghost1 wraps to xmax", int'(char_x), 103);
    end
    char_sel = 3'd0;
    #1;
    check("pac clamped y0", int'(char_y), 0);
    compare_all("wrapclamp");

    // collision approach and release
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    send_dir(2, 4);
    for (int t = 1; t <= 26; t++) begin
      run_tick(0, 0, 0);
      if (t == 25) check("coll at gy75", int'(collision), 0);
      if (t == 26) check("coll at gy76", int'(collision), COLL_EN);
    end
    send_dir(2, 0);
    send_dir(0, 2);
    for (int t = 1; t <= 5; t++) begin
      run_tick(0, 0, 0);
      if (t == 4) check("coll at dx4", int'(collision), COLL_EN);
      if (t == 5) check("coll at dx5", int'(collision), 0);
    end
    compare_all("collide");

    // tick overrun and a direction command held across a busy frame
    wait_ready();
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick      = 1'b0;
    dir_valid = 1'b1;
    dir_char  = 3'd0;
    dir_code  = 3'd1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    check("overrun set", int'(tick_overrun), 1);
    movr      = 1;
    bad_ready = 0;
    cnt       = 0;
    while (busy && cnt < 100) begin
      if (dir_ready) bad_ready = 1;
      cnt++;
      @(posedge clk);
      #1;
    end
    check("ready low while busy", bad_ready, 0);
    check("held cmd not taken", int'(pac_orient), 1);
    model_frame();
    @(posedge clk);
    #1;
    dir_valid = 1'b0;
    model_dir(0, 1);
    compare_all("overrun");
    run_tick(0, 0, 0);
    compare_all("after overrun");

    // asynchronous reset in the middle of UPDATE
    wait_ready();
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midreset busy", int'(busy), 0);
    check("midreset dir_ready", int'(dir_ready), 1);
    check("midreset overrun", int'(tick_overrun), 0);
    for (int i = 0; i < N; i++) begin
      char_sel = rst_tab[i].sel;
      #0.5;
      check($sformatf("midreset x%0d", i), int'(char_x), rst_tab[i].x);
      check($sformatf("midreset y%0d", i), int'(char_y), rst_tab[i].y);
    end
    reset_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;

    // randomized commands and frames, including same-cycle direction + tick
    for (int it = 0; it < 40; it++) begin
      cnt = $urandom_range(0, 2);
      for (int k = 0; k < cnt; k++) send_dir($urandom_range(0, 7), $urandom_range(0, 7));
      run_tick($urandom_range(0, 1), $urandom_range(0, 5), $urandom_range(0, 7));
      compare_all($sformatf("rand%0d", it));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
